// File: rtl/clt_noise_accumulator.sv
// CLT Gaussian noise: sums NPAIR pairs of 12-bit uniforms and re-centres
// the total into a signed 16-bit sample held until the consumer takes it.
module clt_noise_accumulator #(
    parameter int          NPAIR  = 8,
    parameter logic [15:0] OFFSET = 16'h8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] u1,
    input  logic [31:0] u2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] noise,
    output logic [15:0] out_count
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [3:0] LAST = 4'(NPAIR - 1);

    state_t      state, state_nxt;
    logic [15:0] acc, acc_nxt;
    logic [3:0]  cnt, cnt_nxt;
    logic [15:0] noise_nxt;
    logic [15:0] count_nxt;
    logic [11:0] a, b;
    logic [15:0] sum;
    logic        unused_bits;

    assign a           = u1[31:20];
    assign b           = u2[31:20];
    assign unused_bits = ^{u1[19:0], u2[19:0]};
    // 16 x 4095 fits in 16 bits, so this never wraps
    assign sum         = acc + 16'(a) + 16'(b);

    assign in_ready  = rst && (state == ACC);
    assign out_valid = (state == HOLD);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            noise     <= '0;
            out_count <= '0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            noise     <= noise_nxt;
            out_count <= count_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        noise_nxt = noise;
        count_nxt = out_count;
        unique case (state)
            ACC: begin
                if (in_valid) begin
                    if (cnt == LAST) begin
                        noise_nxt = sum - OFFSET;
                        acc_nxt   = '0;
                        cnt_nxt   = '0;
                        state_nxt = HOLD;
                    end else begin
                        acc_nxt = sum;
                        cnt_nxt = cnt + 4'd1;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_nxt = ACC;
                    count_nxt = out_count + 16'd1;
                end
            end
            default: state_nxt = ACC;
        endcase
    end

endmodule

// File: tb/tb_clt_noise_accumulator.sv
// Directed bench for clt_noise_accumulator with a scoreboard of expected
// noise samples popped at each output handshake.
module tb_clt_noise_accumulator;

    localparam int NP = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] u1, u2;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] noise;
    logic [15:0] out_count;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] sb[$];
    logic [15:0] exp_count;
    logic [15:0] last_exp;

    always #5 clk = ~clk;

    clt_noise_accumulator #(.NPAIR(NP), .OFFSET(16'h8000)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .u1(u1), .u2(u2), .out_valid(out_valid), .out_ready(out_ready),
        .noise(noise), .out_count(out_count)
    );

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard: compare at negedge where the handshake will complete
    always @(negedge clk) begin
        if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_empty", 16'd1, 16'd0);
            end else begin
                check("noise", noise, sb.pop_front());
            end
        end
    end

    // One sample of NP beats; step varies the words per beat
    task automatic sample(input logic [31:0] a0, input logic [31:0] b0,
                          input logic [31:0] step, input bit gap);
        logic [15:0] s;
        s = 16'd0;
        for (int i = 0; i < NP; i++) begin
            u1 = a0 + step * i;
            u2 = b0 - step * i;
            s  = s + {4'd0, u1[31:20]} + {4'd0, u2[31:20]};
            in_valid = 1'b1;
            if (i == NP - 1) begin
                last_exp = s - 16'h8000;
                sb.push_back(last_exp);
            end
            @(posedge clk); #1;
            if (i < NP - 1) check("ov_early", {15'd0, out_valid}, 16'd0);
            else            check("ov_latency", {15'd0, out_valid}, 16'd1);
            if (gap && i < NP - 1) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        check("ir_hold", {15'd0, in_ready}, 16'd0);
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        exp_count = exp_count + 16'd1;
        check("ov_drop", {15'd0, out_valid}, 16'd0);
        check("ir_back", {15'd0, in_ready}, 16'd1);
        check("out_count", out_count, exp_count);
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        u1 = '0; u2 = '0; exp_count = '0; last_exp = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", {15'd0, in_ready}, 16'd0);
        check("rst_out_valid", {15'd0, out_valid}, 16'd0);
        check("rst_noise", noise, 16'h0000);
        check("rst_count", out_count, 16'd0);
        rst = 1'b1;
        #1;
        check("rel_in_ready", {15'd0, in_ready}, 16'd1);

        // zeros, all-ones, mixed half-scale
        sample(32'h0, 32'h0, 32'h0, 1'b0);
        check("zero_noise", noise, 16'h8000);
        drain();
        sample(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0);
        check("ones_noise", noise, 16'h7FF0);
        drain();
        sample(32'h80000000, 32'h7FFFFFFF, 32'h0, 1'b0);
        check("neg_noise", noise, 16'hFFF8);
        drain();

        // backpressure: HOLD ignores in_valid and keeps noise stable
        sample(32'h12345678, 32'hCAFEBABE, 32'h01357000, 1'b0);
        for (int k = 0; k < 5; k++) begin
            u1 = 32'hFFFFFFFF; u2 = 32'hFFFFFFFF; in_valid = 1'b1;
            @(posedge clk); #1;
            check("bp_valid", {15'd0, out_valid}, 16'd1);
            check("bp_ready", {15'd0, in_ready}, 16'd0);
            check("bp_noise", noise, last_exp);
        end
        in_valid = 1'b0;
        drain();
        // proves no beat was swallowed while held
        sample(32'h0, 32'h0, 32'h0, 1'b0);
        check("bp_next", noise, 16'h8000);
        drain();

        // reset mid-accumulation discards the partial sum
        for (int i = 0; i < 5; i++) begin
            u1 = 32'h0; u2 = 32'h0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready", {15'd0, in_ready}, 16'd0);
        check("mid_rst_count", out_count, 16'd0);
        rst = 1'b1;
        exp_count = '0;
        sample(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b0);
        check("rst_ones", noise, 16'h7FF0);
        drain();

        // gapped input, out_ready held high during ACC
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("acc_ign_ready", out_count, exp_count);
        out_ready = 1'b0;
        sample(32'h9ABC0000, 32'h11110000, 32'h00F00000, 1'b1);
        drain();
        sample(32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 1'b1);
        check("gap_ones", noise, 16'h7FF0);
        drain();
        check("gap_count", out_count, 16'd3);

        check("sb_left", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
